handshake_initiator: RTL and testbench
======================================

HANDSHAKE_INITIATOR -- requirements
Module: handshake_initiator

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, legal 2..4: synchronizer depth on ack_i.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: REQ-state cycles before abort; 0 disables timeout.
REQ-004 clk  input  1  single clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  local request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_data  input  DATA_WIDTH  request payload, sampled on accept.
REQ-009 stb_o  output  1  four-phase strobe to the far side, registered.
REQ-010 data_o  output  DATA_WIDTH  held payload, registered.
REQ-011 ack_i  input  1  four-phase acknowledge, asynchronous to clk.
REQ-012 done  output  1  one-cycle pulse: transaction completed.
REQ-013 timeout  output  1  one-cycle pulse: transaction aborted.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 ack_i SHALL pass through SYNC_STAGES flops before use; the synchronized value is ack_s.
REQ-016 FSM states SHALL be IDLE, REQ, RELEASE and ABORT.
REQ-017 req_ready SHALL be high only in IDLE with ack_s==0.
REQ-018 Accept SHALL occur when req_valid&req_ready: data_o<=req_data, state<=REQ, stb_o<=1; stb_o rises the cycle after accept.
REQ-019 data_o SHALL remain stable from accept until the FSM re-enters IDLE.
REQ-020 In REQ, ack_s==1 SHALL cause stb_o<=0 and state<=RELEASE.
REQ-021 In RELEASE, ack_s==0 SHALL cause a done pulse for one cycle and state<=IDLE.
REQ-022 The timeout counter (width clog2(TIMEOUT_CYCLES+1)) SHALL clear on accept and increment each cycle in REQ.
REQ-023 Timeout SHALL fire in REQ when counter==TIMEOUT_CYCLES-1 and ack_s==0: stb_o<=0, timeout pulse, state<=ABORT.
REQ-024 If ack_s==1 and the timeout condition occur in the same cycle, the ack SHALL win: no timeout, go to RELEASE.
REQ-025 In ABORT, the FSM SHALL wait for ack_s==0, then return to IDLE with no done pulse.
REQ-026 With TIMEOUT_CYCLES==0, the timeout and ABORT paths SHALL be unreachable.
REQ-027 A stale ack_s==1 in IDLE SHALL block accept (per REQ-017) until it drops.
REQ-028 done and timeout SHALL never be high in the same cycle.
REQ-029 Minimum transaction latency from accept to done SHALL be 2*SYNC_STAGES+3 cycles with an immediately responding far side.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, stb_o=0, data_o=0, done=0, timeout=0, counter=0 and synchronizer flops=0.
REQ-031 Reset mid-transaction SHALL drop stb_o asynchronously, with no done or timeout pulse.
REQ-032 After reset release, the first accept SHALL be possible once ack_s==0.

Structure
REQ-033 The FSM state enum and the state encoding width SHALL reside in the shared package handshake_pkg.
REQ-034 The ack synchronizer SHALL be a separate sub-module, sync_ff, with parameter STAGES, async active-low reset, and shift-register extraction disabled.
REQ-035 All outputs SHALL be driven directly from flops, except req_ready and busy, which decode the state.

Verification
REQ-036 Basic: accept 0xDEADBEEF, far side acks 1 cycle after stb_o and releases 1 cycle after stb_o falls -> data_o=0xDEADBEEF throughout, one done pulse, busy low after done.
REQ-037 Timeout: TIMEOUT_CYCLES=16, ack_i held 0 -> stb_o falls after 16 REQ cycles, one timeout pulse, no done.
REQ-038 Race: ack_s rises on the counter's terminal cycle -> RELEASE taken, done later, timeout never asserted.
REQ-039 Reset mid-op: assert rst_n low while in RELEASE -> stb_o=0 at once, no pulses, req_ready returns once ack_s==0.
REQ-040 Stale ack: ack_i held 1 after an abort, with req_valid high -> req_ready stays 0 until ack_s==0, then accept on that cycle.
REQ-041 Back-to-back: req_valid held high with 3 payloads 0x1, 0x2, 0x3 -> 3 transactions in order, 3 done pulses, stb_o never high while ack_s==1 at accept.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared types for the four-phase handshake initiator.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package handshake_pkg;

    // State register width, shared so any probe/debug logic decodes the same encoding.
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2,
        ABORT   = 2'd3
    } hsState_t;

    // Timeout counter width; a zero cycle count still needs a 1-bit counter to stay legal.
    function automatic int cntWidth(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; samples every cycle.
//   clk   : sampling clock
//   rst_n : async active-low reset, clears every stage
//   d     : asynchronous input level
//   q     : synchronized level
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    // Keep the chain as discrete flops so the tools place them tightly and never fold
    // them into an SRL primitive, which would defeat metastability settling.
    (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [STAGES-1:0] syncReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncReg <= '0;
        end else begin
            syncReg <= {syncReg[STAGES-2:0], d};
        end
    end

    assign q = syncReg[STAGES-1];

endmodule

// File: rtl/handshake_initiator.sv
// Four-phase req/ack initiator: latches a local request and strobes it to an async far side.
// Latency: accept-to-done is 2*SYNC_STAGES+3 cycles with an immediately responding far side.
// Backpressure: req_ready is low while a transaction is in flight or a stale ack is still high.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : local request handshake, req_data sampled on accept
//   stb_o, data_o       : registered strobe and held payload toward the far side
//   ack_i               : asynchronous acknowledge from the far side
//   done, timeout, busy : completion pulse, abort pulse, not-idle status
module handshake_initiator
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 2,   // 2..4
    parameter int TIMEOUT_CYCLES = 1024 // 0 disables the timeout
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  stb_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ack_i,
    output logic                  done,
    output logic                  timeout,
    output logic                  busy
);

    localparam int               CNT_W    = cntWidth(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic                  ackS;
    hsState_t              state, stateNext;
    logic [CNT_W-1:0]      count, countNext;
    logic                  stbNext;
    logic [DATA_WIDTH-1:0] dataNext;
    logic                  doneNext;
    logic                  timeoutNext;
    logic                  timeoutHit;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ackSync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack_i),
        .q     (ackS)
    );

    // A stale ack (far side still high from an aborted transfer) must drop first.
    assign req_ready = (state == IDLE) && !ackS;
    assign busy      = (state != IDLE);

    // Constant-false when the timeout is disabled, so ABORT can never be entered.
    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (count == CNT_LAST);

    always_comb begin
        stateNext   = state;
        countNext   = count;
        stbNext     = stb_o;
        dataNext    = data_o;
        doneNext    = 1'b0;
        timeoutNext = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    dataNext  = req_data;
                    stbNext   = 1'b1;
                    countNext = '0;
                    stateNext = REQ;
                end
            end
            REQ: begin
                countNext = count + CNT_W'(1);
                // Ack is checked first so a late ack on the terminal cycle still completes.
                if (ackS) begin
                    stbNext   = 1'b0;
                    stateNext = RELEASE;
                end else if (timeoutHit) begin
                    stbNext     = 1'b0;
                    timeoutNext = 1'b1;
                    stateNext   = ABORT;
                end
            end
            RELEASE: begin
                if (!ackS) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            ABORT: begin
                // Wait out the far side silently; no done for an aborted transfer.
                if (!ackS) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            stb_o   <= 1'b0;
            data_o  <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= stateNext;
            count   <= countNext;
            stb_o   <= stbNext;
            data_o  <= dataNext;
            done    <= doneNext;
            timeout <= timeoutNext;
        end
    end

endmodule

// File: tb/tb_handshake_initiator.sv
// Directed bench for handshake_initiator (DATA_WIDTH=32, SYNC_STAGES=2, TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge.
// Cycle 0 of each scenario is the cycle in which the request is accepted.
module tb_handshake_initiator;

    localparam int DW = 32;
    localparam int SS = 2;
    localparam int TO = 16;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_data  = '0;
    logic          stb_o;
    logic [DW-1:0] data_o;
    logic          ack_i     = 1'b0;
    logic          done;
    logic          timeout;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    handshake_initiator #(
        .DATA_WIDTH     (DW),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .stb_o     (stb_o),
        .data_o    (data_o),
        .ack_i     (ack_i),
        .done      (done),
        .timeout   (timeout),
        .busy      (busy)
    );

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; ack_i = 1'b0; req_data = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({stb_o, done, timeout, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got stb/done/to/busy=%b want 0000", {stb_o, done, timeout, busy});
        end
        vectors++;
        if (data_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 00000000", data_o);
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Far side raises ack one cycle after seeing stb_o and drops it one cycle after stb_o falls.
    task automatic test_basic();
        int   doneCnt  = 0;
        int   doneAt   = -1;
        int   unstable = 0;
        logic stbPrev  = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_data = 32'hDEADBEEF;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_ready: got %b want 1", req_ready);
        end
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                vectors++;
                if (stb_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL basic_stb_rise: got %b want 1", stb_o);
                end
            end
            if (busy && data_o !== 32'hDEADBEEF) unstable++;
            if (timeout) unstable++;
            if (done) begin doneCnt++; doneAt = c; end
            if (c == 9) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic_busy_after_done: got %b want 0", busy);
                end
            end
            ack_i   = stbPrev;
            stbPrev = stb_o;
        end
        vectors++;
        if (doneCnt != 1 || doneAt != 9) begin
            miscompares++;
            $display("FAIL basic_done: got count=%0d cycle=%0d want count=1 cycle=9", doneCnt, doneAt);
        end
        vectors++;
        if (unstable != 0) begin
            miscompares++;
            $display("FAIL basic_data_stable: got %0d bad cycles want 0", unstable);
        end
    endtask

    task automatic test_timeout();
        int stbHigh = 0;
        int toCnt   = 0;
        int toAt    = -1;
        int doneCnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_data = 32'h00000A5A; ack_i = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (stb_o) stbHigh++;
            if (timeout) begin toCnt++; toAt = c; end
            if (done) doneCnt++;
            if (c == 18) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL timeout_idle: got busy=%b want 0", busy);
                end
            end
        end
        vectors++;
        if (stbHigh != 16) begin
            miscompares++;
            $display("FAIL timeout_stb_len: got %0d want 16", stbHigh);
        end
        vectors++;
        if (toCnt != 1 || toAt != 17) begin
            miscompares++;
            $display("FAIL timeout_pulse: got count=%0d cycle=%0d want count=1 cycle=17", toCnt, toAt);
        end
        vectors++;
        if (doneCnt != 0) begin
            miscompares++;
            $display("FAIL timeout_no_done: got %0d want 0", doneCnt);
        end
    endtask

    // ack_i rises at cycle 14 so the synchronized ack lands exactly on counter==15.
    task automatic test_race();
        int stbHigh = 0;
        int toCnt   = 0;
        int doneCnt = 0;
        int doneAt  = -1;
        @(negedge clk);
        req_valid = 1'b1; req_data = 32'h12345678; ack_i = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (stb_o) stbHigh++;
            if (timeout) toCnt++;
            if (done) begin doneCnt++; doneAt = c; end
            if (c == 14) ack_i = 1'b1;
            if (c == 17) ack_i = 1'b0;
        end
        vectors++;
        if (toCnt != 0) begin
            miscompares++;
            $display("FAIL race_no_timeout: got %0d pulses want 0", toCnt);
        end
        vectors++;
        if (doneCnt != 1 || doneAt != 20) begin
            miscompares++;
            $display("FAIL race_done: got count=%0d cycle=%0d want count=1 cycle=20", doneCnt, doneAt);
        end
        vectors++;
        if (stbHigh != 16) begin
            miscompares++;
            $display("FAIL race_stb_len: got %0d want 16", stbHigh);
        end
    endtask

    // Abort, then the far side acks late and holds it; accept must wait for ack_s to clear.
    task automatic test_stale();
        int staleErr = 0;
        int doneAt   = -1;
        @(negedge clk);
        req_valid = 1'b1; req_data = 32'h0BADF00D; ack_i = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (c == 17) begin
                vectors++;
                if (timeout !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stale_abort: got timeout=%b want 1", timeout);
                end
                ack_i = 1'b1;
            end
            if (c == 19) begin req_valid = 1'b1; req_data = 32'h57A1E000; end
            if (c >= 19 && c <= 25 && req_ready !== 1'b0) staleErr++;
            if (c == 24) ack_i = 1'b0;
            if (c == 26) begin
                vectors++;
                if (req_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stale_ready_return: got %b want 1", req_ready);
                end
            end
            if (c == 27) begin
                req_valid = 1'b0;
                vectors++;
                if (stb_o !== 1'b1 || data_o !== 32'h57A1E000) begin
                    miscompares++;
                    $display("FAIL stale_accept: got stb=%b data=%h want stb=1 data=57a1e000", stb_o, data_o);
                end
            end
            if (done) doneAt = c;
            if (c >= 27) ack_i = stb_o;
        end
        vectors++;
        if (staleErr != 0) begin
            miscompares++;
            $display("FAIL stale_ready_blocked: got %0d ready cycles want 0", staleErr);
        end
        vectors++;
        if (doneAt != 33) begin
            miscompares++;
            $display("FAIL stale_done: got cycle=%0d want 33", doneAt);
        end
    endtask

    // Immediate responder: ack_i follows stb_o; each accept happens on the cycle done is seen.
    task automatic test_back_to_back();
        logic [31:0] payload [3] = '{32'h1, 32'h2, 32'h3};
        int idx     = 0;
        int doneCnt = 0;
        int lastAcc = 0;
        int toCnt   = 0;
        bit acc     = 1'b0;
        ack_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (acc) begin
                vectors++;
                if (stb_o !== 1'b1 || data_o !== payload[idx-1]) begin
                    miscompares++;
                    $display("FAIL b2b_launch%0d: got stb=%b data=%h want stb=1 data=%h",
                             idx, stb_o, data_o, payload[idx-1]);
                end
            end
            if (timeout) toCnt++;
            if (done) begin
                doneCnt++;
                vectors++;
                if (c - lastAcc != 2*SS+3 || doneCnt != idx) begin
                    miscompares++;
                    $display("FAIL b2b_done%0d: got latency=%0d order=%0d want latency=%0d order=%0d",
                             doneCnt, c - lastAcc, idx, 2*SS+3, doneCnt);
                end
            end
            ack_i     = stb_o;
            req_valid = (idx < 3);
            if (idx < 3) req_data = payload[idx];
            acc = 1'b0;
            if (req_valid && req_ready) begin
                vectors++;
                if (stb_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_stb_at_accept: got %b want 0", stb_o);
                end
                acc     = 1'b1;
                lastAcc = c;
                idx++;
            end
        end
        req_valid = 1'b0;
        vectors++;
        if (doneCnt != 3 || idx != 3 || toCnt != 0) begin
            miscompares++;
            $display("FAIL b2b_totals: got done=%0d accepts=%0d timeouts=%0d want 3 3 0", doneCnt, idx, toCnt);
        end
    endtask

    task automatic test_reset_midop();
        int pulses = 0;
        // Reset while the strobe is high: it must drop without a clock edge.
        @(negedge clk);
        req_valid = 1'b1; req_data = 32'hCAFE0001; ack_i = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if (stb_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midreq_stb_before: got %b want 1", stb_o);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({stb_o, busy, done, timeout} !== 4'b0000 || data_o !== 32'h0) begin
            miscompares++;
            $display("FAIL midreq_async: got stb/busy/done/to=%b data=%h want 0000 00000000",
                     {stb_o, busy, done, timeout}, data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Reset while in RELEASE (ack_s still high from the far side).
        @(negedge clk);
        req_valid = 1'b1; req_data = 32'hCAFE0002;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            ack_i = stb_o;
        end
        vectors++;
        if (busy !== 1'b1 || stb_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midrel_state: got busy=%b stb=%b want busy=1 stb=0", busy, stb_o);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({stb_o, busy, done, timeout} !== 4'b0000 || data_o !== 32'h0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrel_async: got stb/busy/done/to=%b data=%h ready=%b want 0000 00000000 1",
                     {stb_o, busy, done, timeout}, data_o, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || timeout) pulses++;
        end
        vectors++;
        if (pulses != 0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midop_after: got pulses=%0d ready=%b want 0 1", pulses, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_race();
        test_stale();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
